// File: rtl/delay_measure_ctrl.sv
// rtl/delay_measure_ctrl.sv - round-trip edge delay measurement controller with sum/min/max accumulation
module delay_measure_ctrl #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int INVERT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       num_trials,
  output logic             path_in,
  input  logic             path_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err,
  output logic [7:0]       trial_cnt,
  output logic [CNT_W-1:0] last_delay,
  output logic [CNT_W-1:0] min_delay,
  output logic [CNT_W-1:0] max_delay,
  output logic [CNT_W+7:0] delay_sum
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_RECORD  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int   SW      = $clog2(SETTLE_CYC + 1);
  localparam logic INV_BIT = (INVERT != 0);

  logic [2:0]             state;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic                   expected;
  logic [SW-1:0]          settle_cnt;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             trials_lat;

  assign sync_q   = sync_r[SYNC_STAGES-1];
  // Level the returned signal must show once the path has caught up with path_in.
  assign expected = path_in ^ INV_BIT;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // Synchronizer chain for the asynchronous path return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], path_out};
    end
  end

  // Measurement sequencer: settle, launch an edge, count until it returns, accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      path_in    <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
      trial_cnt  <= '0;
      last_delay <= '0;
      min_delay  <= '1;
      max_delay  <= '0;
      delay_sum  <= '0;
      settle_cnt <= '0;
      cnt        <= '0;
      trials_lat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            trials_lat <= num_trials;
            trial_cnt  <= '0;
            last_delay <= '0;
            min_delay  <= '1;
            max_delay  <= '0;
            delay_sum  <= '0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            settle_cnt <= '0;
            state      <= (num_trials == 8'd0) ? S_DONE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            settle_cnt <= '0;
            if (sync_q == expected) begin
              state <= S_LAUNCH;
            end else begin
              err   <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_LAUNCH: begin
          // The counter reads 1 in the first MEASURE cycle after the edge leaves.
          path_in <= ~path_in;
          cnt     <= CNT_W'(1);
          state   <= S_MEASURE;
        end
        S_MEASURE: begin
          // Detection wins over timeout when both occur on the same cycle.
          if (sync_q == expected) begin
            state <= S_RECORD;
          end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RECORD: begin
          last_delay <= cnt;
          delay_sum  <= delay_sum + {8'd0, cnt};
          if (cnt < min_delay) min_delay <= cnt;
          if (cnt > max_delay) max_delay <= cnt;
          trial_cnt  <= trial_cnt + 8'd1;
          state      <= (trial_cnt + 8'd1 == trials_lat) ? S_DONE : S_SETTLE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/delay_measure_ctrl.md
Name: delay_measure_ctrl

Overview:
Controller at the driving end of a delay-path under test. Launches alternating edges into the path and samples the returned signal through a synchronizer. Times each edge's round trip in clock cycles, with on-chip accumulation of sum, minimum and maximum over a requested number of trials. Sits between host logic (start/results) and the delay path instance (path_in drives the path input, path_out returns the path result).

Parameters:
CNT_W, 32, width of per-trial cycle counter and min/max/last results
SYNC_STAGES, 2, flip-flop stages on path_out before comparison (min 2)
SETTLE_CYC, 16, idle cycles held before each launch so the path is quiescent
TIMEOUT_CYC, 4096, MEASURE cycles without detection before abort
INVERT, 0, 1 if the path under test is logically inverting

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a run; ignored while busy
num_trials  input  8  number of edges to time; sampled on accepted start
path_in  output  1  drive to delay path input
path_out  input  1  asynchronous return from delay path
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse at end of run (normal, timeout or error)
timeout  output  1  sticky: a trial exceeded TIMEOUT_CYC; cleared on next accepted start
err  output  1  sticky: path_out did not match expected level after settle; cleared on next start
trial_cnt  output  8  completed trials in current/last run
last_delay  output  CNT_W  delay of most recent completed trial
min_delay  output  CNT_W  minimum over run; all-ones if no trial completed
max_delay  output  CNT_W  maximum over run; 0 if no trial completed
delay_sum  output  CNT_W+8  sum of completed trial delays; no overflow possible

Behaviour:
- Reset (async, rst_n low): state IDLE; path_in=0, synchronizer=0, busy=0, done=0, timeout=0, err=0, trial_cnt=0, last_delay=0, min_delay=all-ones, max_delay=0, delay_sum=0. Reset mid-run aborts with no done pulse.
- expected = path_in XOR INVERT; sync_q = last synchronizer stage.
- IDLE: start=1 -> latch num_trials, clear trial_cnt/sums/min/max/timeout/err, go SETTLE. If latched num_trials=0 -> go DONE directly.
- SETTLE: settle counter runs SETTLE_CYC cycles. At the final cycle: sync_q==expected -> LAUNCH; else set err -> DONE.
- LAUNCH (1 cycle): path_in toggles at the exiting edge; cycle counter loaded so that the first MEASURE cycle shows 1.
- MEASURE: counter increments each cycle. First cycle in which sync_q==expected (new level) -> capture counter value k as the trial delay -> RECORD.
  - Counter reaching TIMEOUT_CYC without detection -> set timeout -> DONE; the trial is not recorded.
  - Timing: a path whose output changes D clock edges after path_in yields k = D + SYNC_STAGES + 1. A zero-delay loopback yields SYNC_STAGES+1.
- RECORD (1 cycle): last_delay=k; delay_sum+=k; min/max updated; trial_cnt++. Then trial_cnt==latched count -> DONE; else SETTLE.
- Successive trials therefore alternate rising and falling edges. path_in retains its final level after the run.
- DONE (1 cycle): done=1 -> IDLE. Results hold until next accepted start.
- busy=1 in SETTLE, LAUNCH, MEASURE, RECORD, DONE.
- start asserted while busy or in DONE: ignored, no effect.

Test Plan:
- Zero-delay loopback, SYNC_STAGES=2, num_trials=4 -> last=min=max=3, sum=12, trial_cnt=4, done one pulse, path_in ends 0.
- Path model delaying path_in by 5 cycles, num_trials=4 -> each delay 8, sum=32, timeout=0, err=0.
- Inverting model (INVERT=1, D=5) with path_out = ~delayed path_in, num_trials=3 -> delays 8, path_in ends 1; with INVERT=0 on the same model -> err=1 and done after first settle, trial_cnt=0.
- path_out tied low, num_trials=2 -> first trial in rising direction, timeout=1 after TIMEOUT_CYC MEASURE cycles, trial_cnt=0, min=all-ones, max=0.
- num_trials=0 -> done two cycles after start, all results cleared, path_in unchanged.
- rst_n low mid-MEASURE -> all outputs reset values immediately (async), no done pulse. start pulsed while busy -> run completes with original num_trials, no restart.
